// File: rtl/l2_cache_pkg.sv
// Shared opcodes, FIFO entry/beat layouts and beat-building helpers for the
// multi-core L2 response stage.
package l2_cache_pkg;

    localparam int MAX_CORES = 8;

    localparam logic [2:0] L2REQ_LOAD       = 3'd0;
    localparam logic [2:0] L2REQ_STORE      = 3'd1;
    localparam logic [2:0] L2REQ_FLUSH      = 3'd2;
    localparam logic [2:0] L2REQ_INVALIDATE = 3'd3;
    localparam logic [2:0] L2REQ_LOAD_SYNC  = 3'd4;
    localparam logic [2:0] L2REQ_STORE_SYNC = 3'd5;

    localparam logic [1:0] L2RSP_LOAD_ACK  = 2'd1;
    localparam logic [1:0] L2RSP_STORE_ACK = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_UPD  = 2'd2
    } rsp_state_t;

    // Entry metadata is sized for the largest core count; unused upper bits stay zero.
    typedef struct packed {
        logic [2:0]               core;
        logic [1:0]               unit;
        logic [1:0]               strand;
        logic [1:0]               way;
        logic [1:0]               rsp_op;
        logic                     is_store;
        logic                     status;
        logic [MAX_CORES-1:0]     has_line;
        logic [2*MAX_CORES-1:0]   dir_way;
    } l2_entry_t;

    typedef struct packed {
        logic       valid;
        logic       status;
        logic       update;
        logic [1:0] unit;
        logic [1:0] strand;
        logic [1:0] op;
        logic [1:0] way;
    } l2_beat_t;

    function automatic logic is_store_op(logic [2:0] op);
        return (op == L2REQ_STORE) || (op == L2REQ_STORE_SYNC);
    endfunction

    function automatic logic [1:0] rsp_op_of(logic [2:0] op);
        case (op)
            L2REQ_LOAD, L2REQ_LOAD_SYNC:   return L2RSP_LOAD_ACK;
            L2REQ_STORE, L2REQ_STORE_SYNC: return L2RSP_STORE_ACK;
            default:                       return 2'd0;
        endcase
    endfunction

    function automatic l2_beat_t ack_beat(l2_entry_t e);
        l2_beat_t b;
        logic     hit;
        hit      = e.has_line[e.core];
        b.valid  = 1'b1;
        b.status = e.status;
        b.update = hit && e.is_store;
        b.unit   = e.unit;
        b.strand = e.strand;
        b.op     = e.rsp_op;
        b.way    = hit ? e.dir_way[{e.core, 1'b0} +: 2] : e.way;
        return b;
    endfunction

    function automatic l2_beat_t upd_beat(l2_entry_t e, logic [2:0] c);
        l2_beat_t b;
        b.valid  = 1'b1;
        b.status = 1'b0;
        b.update = 1'b1;
        b.unit   = e.unit;
        b.strand = e.strand;
        b.op     = L2RSP_STORE_ACK;
        b.way    = e.dir_way[{c, 1'b0} +: 2];
        return b;
    endfunction

    // Cores other than the requester that must see a write-update.
    function automatic logic [MAX_CORES-1:0] sharers_of(l2_entry_t e);
        return e.is_store ? (e.has_line & ~(MAX_CORES'(1) << e.core)) : '0;
    endfunction

endpackage

// File: rtl/l2_cache_response_mc_if.sv
// Request (writeback side) and response (interconnect side) bundle of the
// multi-core L2 response stage.
interface l2_cache_response_mc_if #(
    parameter int NUM_CORES = 2,
    parameter int LINE_BITS = 512
);
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic                   wr_l2req_valid;
    logic [CW-1:0]          wr_l2req_core;
    logic [1:0]             wr_l2req_unit;
    logic [1:0]             wr_l2req_strand;
    logic [1:0]             wr_l2req_way;
    logic [2:0]             wr_l2req_op;
    logic [LINE_BITS-1:0]   wr_data;
    logic [NUM_CORES-1:0]   wr_l1_has_line;
    logic [2*NUM_CORES-1:0] wr_dir_l1_way;
    logic                   wr_cache_hit;
    logic                   wr_has_sm_data;
    logic                   wr_store_sync_success;
    logic                   wr_stall;

    logic                   l2rsp_ready;
    logic                   l2rsp_valid;
    logic                   l2rsp_status;
    logic                   l2rsp_update;
    logic [CW-1:0]          l2rsp_core;
    logic [1:0]             l2rsp_unit;
    logic [1:0]             l2rsp_strand;
    logic [1:0]             l2rsp_op;
    logic [1:0]             l2rsp_way;
    logic [LINE_BITS-1:0]   l2rsp_data;
    logic                   l2rsp_overflow;

    modport master (
        output wr_l2req_valid, wr_l2req_core, wr_l2req_unit, wr_l2req_strand,
               wr_l2req_way, wr_l2req_op, wr_data, wr_l1_has_line, wr_dir_l1_way,
               wr_cache_hit, wr_has_sm_data, wr_store_sync_success, l2rsp_ready,
        input  wr_stall, l2rsp_valid, l2rsp_status, l2rsp_update, l2rsp_core,
               l2rsp_unit, l2rsp_strand, l2rsp_op, l2rsp_way, l2rsp_data, l2rsp_overflow
    );

    modport slave (
        input  wr_l2req_valid, wr_l2req_core, wr_l2req_unit, wr_l2req_strand,
               wr_l2req_way, wr_l2req_op, wr_data, wr_l1_has_line, wr_dir_l1_way,
               wr_cache_hit, wr_has_sm_data, wr_store_sync_success, l2rsp_ready,
        output wr_stall, l2rsp_valid, l2rsp_status, l2rsp_update, l2rsp_core,
               l2rsp_unit, l2rsp_strand, l2rsp_op, l2rsp_way, l2rsp_data, l2rsp_overflow
    );
endinterface

// File: rtl/l2_rsp_fifo.sv
// Synchronous FIFO with power-of-two depth, wrapping pointers and a count one
// bit wider than the pointers.
module l2_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/l2_cache_response_mc.sv
// Multi-core L2 response stage: buffers qualified requests and drains them as
// ack beats, plus sharer write-update beats when L2RSP_BROADCAST_EN is defined.
module l2_cache_response_mc
    import l2_cache_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LINE_BITS  = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    l2_cache_response_mc_if.slave bus
);
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int OW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = $bits(l2_entry_t) + LINE_BITS;
    localparam logic [OW-1:0] FULL_OCC  = OW'(FIFO_DEPTH);
    localparam logic [OW-1:0] STALL_OCC = OW'(FIFO_DEPTH - 1);

    rsp_state_t           state_q, state_d;
    l2_beat_t             beat_q, beat_d;
    logic [CW-1:0]        core_q, core_d;
    logic [LINE_BITS-1:0] data_q, data_d;
    logic                 overflow_q, overflow_d;

    l2_entry_t            req_entry, head_entry, load_entry;
    logic [LINE_BITS-1:0] head_data, load_data;
    logic [EW-1:0]        fifo_head;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [OW-1:0]        fifo_count, occ, occ_after;
    logic                 qualify, hs, last_beat, done, bypass;

    l2_rsp_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({req_entry, bus.wr_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_entry, head_data} = fifo_head;

    always_comb begin
        req_entry                            = '0;
        req_entry.core[CW-1:0]               = bus.wr_l2req_core;
        req_entry.unit                       = bus.wr_l2req_unit;
        req_entry.strand                     = bus.wr_l2req_strand;
        req_entry.way                        = bus.wr_l2req_way;
        req_entry.rsp_op                     = rsp_op_of(bus.wr_l2req_op);
        req_entry.is_store                   = is_store_op(bus.wr_l2req_op);
        req_entry.status                     = (bus.wr_l2req_op == L2REQ_STORE_SYNC) &&
                                               bus.wr_store_sync_success;
        req_entry.has_line[NUM_CORES-1:0]    = bus.wr_l1_has_line;
        req_entry.dir_way[2*NUM_CORES-1:0]   = bus.wr_dir_l1_way;
    end

    assign qualify = bus.wr_l2req_valid &&
                     (bus.wr_cache_hit || bus.wr_has_sm_data ||
                      bus.wr_l2req_op == L2REQ_FLUSH || bus.wr_l2req_op == L2REQ_INVALIDATE);

    // The entry in the output stage counts toward occupancy.
    assign occ = fifo_count + OW'(state_q != ST_IDLE);

`ifdef L2RSP_BROADCAST_EN
    l2_entry_t            cur_q, cur_d;
    logic [MAX_CORES-1:0] pend_q, pend_d;
    logic [2:0]           sh_idx;

    always_comb begin
        sh_idx = '0;
        for (int c = MAX_CORES - 1; c >= 0; c--)
            if (pend_q[c])
                sh_idx = 3'(c);
    end

    assign last_beat = (pend_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q  <= '0;
            pend_q <= '0;
        end else begin
            cur_q  <= cur_d;
            pend_q <= pend_d;
        end
    end
`else
    assign last_beat = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        core_d     = core_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        bypass     = 1'b0;
`ifdef L2RSP_BROADCAST_EN
        cur_d      = cur_q;
        pend_d     = pend_q;
`endif
        load_entry = fifo_empty ? req_entry : head_entry;
        load_data  = fifo_empty ? bus.wr_data : head_data;
        hs         = beat_q.valid && bus.l2rsp_ready;
        done       = (state_q == ST_IDLE) || (hs && last_beat);
        occ_after  = occ - OW'(hs && last_beat);

        if (done) begin
            // Buffered entries go first; an empty FIFO lets the request bypass it.
            if (!fifo_empty || qualify) begin
                fifo_pop = !fifo_empty;
                bypass   = fifo_empty;
                state_d  = ST_ACK;
                beat_d   = ack_beat(load_entry);
                core_d   = load_entry.core[CW-1:0];
                data_d   = load_data;
`ifdef L2RSP_BROADCAST_EN
                cur_d    = load_entry;
                pend_d   = sharers_of(load_entry);
`endif
            end else begin
                state_d = ST_IDLE;
                beat_d  = '0;
                core_d  = '0;
                data_d  = '0;
            end
        end
`ifdef L2RSP_BROADCAST_EN
        else if (hs) begin
            state_d = ST_UPD;
            beat_d  = upd_beat(cur_q, sh_idx);
            core_d  = sh_idx[CW-1:0];
            pend_d  = pend_q & ~(MAX_CORES'(1) << sh_idx);
        end
`endif

        if (qualify && !bypass) begin
            if (occ_after < FULL_OCC && !fifo_full)
                fifo_push = 1'b1;
            else
                overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            core_q     <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            core_q     <= core_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.wr_stall       = (occ >= STALL_OCC);
    assign bus.l2rsp_valid    = beat_q.valid;
    assign bus.l2rsp_status   = beat_q.status;
    assign bus.l2rsp_update   = beat_q.update;
    assign bus.l2rsp_core     = core_q;
    assign bus.l2rsp_unit     = beat_q.unit;
    assign bus.l2rsp_strand   = beat_q.strand;
    assign bus.l2rsp_op       = beat_q.op;
    assign bus.l2rsp_way      = beat_q.way;
    assign bus.l2rsp_data     = data_q;
    assign bus.l2rsp_overflow = overflow_q;
endmodule

// File: doc/l2_cache_response_mc.md
# l2_cache_response_mc

Parametrised, multi-core successor of the L2 response stage. Accepts qualified requests from the L2 writeback stage, buffers them in a small FIFO, and drives the L2 response bus under a ready/valid handshake. For stores it also emits write-update packets to every other core whose L1 holds the line. Sits between the L2 writeback stage and the L2 response interconnect.

## Interface
- NUM_CORES, 2, number of L1 clients (2..8); CW = max(1, $clog2(NUM_CORES))
- FIFO_DEPTH, 4, request buffer entries (power of two, ≥2)
- LINE_BITS, 512, cache line width
- clk  in  1  clock; single clock domain, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- wr_l2req_valid  in  1  request presented this cycle
- wr_l2req_core  in  CW  requesting core
- wr_l2req_unit / wr_l2req_strand / wr_l2req_way  in  2 each  request tags
- wr_l2req_op  in  3  L2REQ_* opcode
- wr_data  in  LINE_BITS  line contents after the operation
- wr_l1_has_line  in  NUM_CORES  per-core directory hit
- wr_dir_l1_way  in  2*NUM_CORES  per-core L1 way, core c at [2c+1:2c]
- wr_cache_hit, wr_has_sm_data, wr_store_sync_success  in  1 each
- wr_stall  out  1  FIFO cannot take another request
- l2rsp_ready  in  1  downstream accepts the current beat
- l2rsp_valid, l2rsp_status, l2rsp_update  out  1 each
- l2rsp_core  out  CW; l2rsp_unit, l2rsp_strand, l2rsp_op, l2rsp_way  out  2 each
- l2rsp_data  out  LINE_BITS
- l2rsp_overflow  out  1  sticky error: request arrived while full

## Operation
- Qualify: wr_l2req_valid && (wr_cache_hit || wr_has_sm_data || op==FLUSH || op==INVALIDATE). Others are discarded.
- Response op: LOAD/LOAD_SYNC→L2RSP_LOAD_ACK, STORE/STORE_SYNC→L2RSP_STORE_ACK, all others→0.
- Enqueue stores: tags, op, data, has_line vector, way vector, and status (wr_store_sync_success for STORE_SYNC, else 0).
- Drain FSM states:
  - IDLE: output empty.
  - ACK: beat to the requester. update = has_line[req] && is_store. way = dir way[req] if has_line[req], else req way.
  - UPD: one beat per sharer core c ≠ requester with has_line[c], in ascending c. Fields: core=c, op=STORE_ACK, update=1, way=dir way[c], status=0, unit/strand/data copied from the entry.
- Transitions:
  - IDLE→ACK when an entry is available.
  - ACK→UPD on handshake when the entry is a store and has ≥1 sharer.
  - ACK→ACK for the next entry when none remain in the current one.
  - UPD→UPD on handshake while sharers remain; after the last sharer, next entry (ACK) or IDLE.
- The entry is popped on the handshake of its final beat.
- Beat transfers when l2rsp_valid && l2rsp_ready. Outputs are held stable while valid && !ready.
- wr_stall = occupancy ≥ FIFO_DEPTH−1, where occupancy counts the entry held in the output stage.
- A qualified request while occupancy == FIFO_DEPTH is dropped and sets l2rsp_overflow, which holds until reset.
- Pointer wrap is modulo FIFO_DEPTH. The count is one bit wider than the pointers.

## Timing
- Reset: all outputs 0, FSM IDLE, FIFO empty, l2rsp_overflow 0.
- Reset mid-burst abandons the remaining beats.
- Bypass: a request qualified at edge N with the FIFO empty and output free (or handshaking at N) gives l2rsp_valid=1 after edge N. Latency is 1 cycle.
- Each further beat of the same entry takes 1 cycle per handshake. Throughput is 1 beat/cycle with ready held high.
- Simultaneous push and pop at full: the pop frees the slot first, so the push is accepted with no overflow.
- wr_stall reflects state after the current edge. Upstream must not present a request in the cycle after wr_stall=1.

## Configuration
- L2RSP_BROADCAST_EN
  - Defined: UPD state and sharer update beats as above.
  - Undefined: only the ACK beat is emitted. Sharer bits other than the requester's are ignored and the UPD logic is not synthesised.

## Structure
- Shared package l2_cache_pkg holds the L2REQ_*/L2RSP_* opcodes and the FIFO entry struct typedef.
- One sub-module, l2_rsp_fifo: a parametrised synchronous FIFO with count, full, and empty outputs.
- The FSM, sharer scan (priority encoder over the masked has_line vector), and output register live in the top.

## Test plan
- Load hit, core 1, way 2, ready=1: one beat after 1 cycle with core=1, op=LOAD_ACK, update=0, way=2, status=0.
- STORE_SYNC from core 0, success=1, has_line=4'b1011, dir ways 3/1/x/2, NUM_CORES=4, BROADCAST_EN: three beats.
  - Beat 1: core0 update=1 way=3 status=1.
  - Beat 2: core1 update=1 way=1.
  - Beat 3: core3 update=1 way=2.
- Same stimulus with the macro undefined: a single core0 beat only.
- ready=0 for 10 cycles while issuing requests each cycle:
  - wr_stall rises at occupancy 3 (FIFO_DEPTH=4).
  - A 5th request sets l2rsp_overflow.
  - Outputs stay constant throughout.
- Load miss (cache_hit=0, has_sm_data=0): no beat. A FLUSH miss gives one beat with op=0.
- Assert reset during the second update beat: outputs 0 asynchronously, FIFO empty, next request served normally.
